fp_csr_unit: RTL and testbench

FP_CSR_UNIT -- requirements
Module: fp_csr_unit

---
 rtl/fp_csr_unit.sv | 195 +++++++++++++++++++
 tb/tb_fp_csr_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_csr_unit.sv
// Floating-point CSR unit: fflags/frm/fcsr access, lane flag accumulation,
// per-lane dynamic rounding-mode resolution and FP-state dirty tracking.
module fp_csr_unit #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned XLEN      = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     csr_valid,
  output logic                     csr_ready,
  input  logic [11:0]              csr_addr,
  input  logic [1:0]               csr_op,
  input  logic [XLEN-1:0]          csr_wdata,
  output logic                     csr_rvalid,
  output logic [XLEN-1:0]          csr_rdata,
  output logic                     csr_illegal,
  input  logic [NUM_LANES-1:0]     flag_valid,
  input  logic [5*NUM_LANES-1:0]   flag_data,
  input  logic [3*NUM_LANES-1:0]   rm_in,
  output logic [3*NUM_LANES-1:0]   rm_out,
  output logic [NUM_LANES-1:0]     rm_illegal,
  output logic [2:0]               frm,
  output logic [4:0]               fflags,
  output logic                     fs_dirty
);

  localparam int unsigned FLAG_W = 5;
  localparam int unsigned RM_W   = 3;
  localparam int unsigned CSR_W  = 8;

  localparam logic [11:0] ADDR_FFLAGS = 12'h001;
  localparam logic [11:0] ADDR_FRM    = 12'h002;
  localparam logic [11:0] ADDR_FCSR   = 12'h003;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [FLAG_W-1:0]   fflags_q, fflags_d;
  logic [RM_W-1:0]     frm_q, frm_d;
  logic                dirty_q, dirty_d;
  logic [XLEN-1:0]     rdata_q;
  logic                illegal_q;

  logic                accept;
  logic                addr_ok;
  logic                op_writes;
  logic                commit;
  logic [CSR_W-1:0]    old_val;
  logic [CSR_W-1:0]    mask;
  logic [CSR_W-1:0]    operand;
  logic [CSR_W-1:0]    new_val;
  logic [FLAG_W-1:0]   lane_or;
  logic [FLAG_W-1:0]   fflags_csr;
  logic [RM_W-1:0]     frm_csr;

  // Operand bits above the widest CSR field carry no meaning.
  logic unused_wdata;
  assign unused_wdata = ^csr_wdata[XLEN-1:CSR_W];

  assign csr_ready   = (state_q == IDLE);
  assign csr_rvalid  = (state_q == RESP);
  assign csr_rdata   = rdata_q;
  assign csr_illegal = illegal_q;
  assign frm         = frm_q;
  assign fflags      = fflags_q;
  assign fs_dirty    = dirty_q;

  // Next-state logic: one access accepted, then one response cycle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (csr_valid) begin
          accept  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // OR together the flag reports of every valid lane.
  always_comb begin
    lane_or = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (flag_valid[i]) lane_or = lane_or | flag_data[FLAG_W*i +: FLAG_W];
    end
  end

  // CSR address decode, read-modify-write and next register values.
  always_comb begin
    addr_ok    = 1'b1;
    old_val    = '0;
    mask       = '0;
    new_val    = '0;
    op_writes  = 1'b0;
    fflags_csr = fflags_q;
    frm_csr    = frm_q;
    case (csr_addr)
      ADDR_FFLAGS: begin
        old_val = CSR_W'(fflags_q);
        mask    = 8'h1f;
      end
      ADDR_FRM: begin
        old_val = CSR_W'(frm_q);
        mask    = 8'h07;
      end
      ADDR_FCSR: begin
        old_val = {frm_q, fflags_q};
        mask    = 8'hff;
      end
      default: addr_ok = 1'b0;
    endcase
    operand = csr_wdata[CSR_W-1:0] & mask;
    case (csr_op)
      OP_READ: begin
        new_val   = old_val;
        op_writes = 1'b0;
      end
      OP_WRITE: begin
        new_val   = operand;
        op_writes = 1'b1;
      end
      OP_SET: begin
        new_val   = old_val | operand;
        op_writes = |operand;
      end
      default: begin
        new_val   = old_val & ~operand;
        op_writes = |operand;
      end
    endcase
    commit = accept && addr_ok && op_writes;
    if (commit) begin
      case (csr_addr)
        ADDR_FFLAGS: fflags_csr = new_val[FLAG_W-1:0];
        ADDR_FRM:    frm_csr    = new_val[RM_W-1:0];
        default: begin
          fflags_csr = new_val[FLAG_W-1:0];
          frm_csr    = new_val[CSR_W-1:FLAG_W];
        end
      endcase
    end
    fflags_d = fflags_csr | lane_or;
    frm_d    = frm_csr;
    dirty_d  = dirty_q | commit | (|lane_or);
  end

  // Resolve each lane's rounding mode against the committed frm.
  always_comb begin
    rm_out     = '0;
    rm_illegal = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      case (rm_in[RM_W*i +: RM_W])
        3'b101, 3'b110: rm_illegal[i] = 1'b1;
        3'b111: begin
          if (frm_q > 3'b100) rm_illegal[i] = 1'b1;
          else                rm_out[RM_W*i +: RM_W] = frm_q;
        end
        default: rm_out[RM_W*i +: RM_W] = rm_in[RM_W*i +: RM_W];
      endcase
    end
  end

  // State, CSR registers and response capture; reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      fflags_q  <= '0;
      frm_q     <= '0;
      dirty_q   <= 1'b0;
      rdata_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fflags_q <= fflags_d;
      frm_q    <= frm_d;
      dirty_q  <= dirty_d;
      if (accept) begin
        rdata_q   <= addr_ok ? XLEN'(old_val) : '0;
        illegal_q <= ~addr_ok;
      end
    end
  end

endmodule

// File: tb/tb_fp_csr_unit.sv
// Self-checking bench for fp_csr_unit: directed scenarios plus random traffic
// compared against an abstract register-level reference model.
module tb_fp_csr_unit;

  localparam int unsigned NL   = 2;
  localparam int unsigned XLEN = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              csr_valid;
  logic              csr_ready;
  logic [11:0]       csr_addr;
  logic [1:0]        csr_op;
  logic [XLEN-1:0]   csr_wdata;
  logic              csr_rvalid;
  logic [XLEN-1:0]   csr_rdata;
  logic              csr_illegal;
  logic [NL-1:0]     flag_valid;
  logic [5*NL-1:0]   flag_data;
  logic [3*NL-1:0]   rm_in;
  logic [3*NL-1:0]   rm_out;
  logic [NL-1:0]     rm_illegal;
  logic [2:0]        frm;
  logic [4:0]        fflags;
  logic              fs_dirty;

  fp_csr_unit #(.NUM_LANES(NL), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_addr(csr_addr),
    .csr_op(csr_op), .csr_wdata(csr_wdata), .csr_rvalid(csr_rvalid),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .flag_valid(flag_valid), .flag_data(flag_data), .rm_in(rm_in),
    .rm_out(rm_out), .rm_illegal(rm_illegal), .frm(frm), .fflags(fflags),
    .fs_dirty(fs_dirty)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [4:0]      m_fflags;
  logic [2:0]      m_frm;
  logic            m_dirty;
  logic            m_resp;
  logic [XLEN-1:0] m_rdata;
  logic            m_ill;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // {illegal, mode} for an instruction rm field given the current frm.
  function automatic logic [3:0] rm_ref(input logic [2:0] rm, input logic [2:0] f);
    if (rm <= 3'd4) return {1'b0, rm};
    if (rm == 3'd7 && f <= 3'd4) return {1'b0, f};
    return 4'b1000;
  endfunction

  // Check combinational outputs, advance the model by one clock, check state.
  task automatic step();
    logic [4:0] lor;
    logic [7:0] old, msk, opnd, nv;
    logic [4:0] nf;
    logic [2:0] nr;
    logic       wr, ok;
    logic [3:0] r;
    #1;
    for (int i = 0; i < int'(NL); i++) begin
      r = rm_ref(rm_in[3*i +: 3], m_frm);
      check("rm_out", 64'(rm_out[3*i +: 3]), 64'(r[2:0]));
      check("rm_illegal", 64'(rm_illegal[i]), 64'(r[3]));
    end
    check("csr_ready", 64'(csr_ready), 64'(!m_resp));
    if (reset) begin
      m_fflags = '0; m_frm = '0; m_dirty = 1'b0; m_resp = 1'b0;
      m_rdata = '0; m_ill = 1'b0;
    end else begin
      lor = '0;
      for (int i = 0; i < int'(NL); i++)
        if (flag_valid[i]) lor = lor | flag_data[5*i +: 5];
      nf = m_fflags; nr = m_frm; wr = 1'b0;
      if (csr_valid && !m_resp) begin
        ok = 1'b1; old = '0; msk = '0;
        case (csr_addr)
          12'h001: begin old = {3'b000, m_fflags}; msk = 8'h1f; end
          12'h002: begin old = {5'b00000, m_frm};  msk = 8'h07; end
          12'h003: begin old = {m_frm, m_fflags};  msk = 8'hff; end
          default: ok = 1'b0;
        endcase
        opnd = csr_wdata[7:0] & msk;
        nv = old;
        case (csr_op)
          2'd1: begin nv = opnd;        wr = 1'b1; end
          2'd2: begin nv = old | opnd;  wr = (opnd != 0); end
          2'd3: begin nv = old & ~opnd; wr = (opnd != 0); end
          default: wr = 1'b0;
        endcase
        if (!ok) wr = 1'b0;
        if (wr) begin
          if (csr_addr == 12'h001) nf = nv[4:0];
          else if (csr_addr == 12'h002) nr = nv[2:0];
          else begin nf = nv[4:0]; nr = nv[7:5]; end
        end
        m_rdata = ok ? XLEN'(old) : '0;
        m_ill   = !ok;
        m_resp  = 1'b1;
      end else begin
        m_resp = 1'b0;
      end
      m_fflags = nf | lor;
      m_frm    = nr;
      m_dirty  = m_dirty | wr | (lor != 0);
    end
    @(posedge clock);
    #1;
    check("fflags", 64'(fflags), 64'(m_fflags));
    check("frm", 64'(frm), 64'(m_frm));
    check("fs_dirty", 64'(fs_dirty), 64'(m_dirty));
    check("csr_rvalid", 64'(csr_rvalid), 64'(m_resp));
    check("csr_rdata", 64'(csr_rdata), 64'(m_rdata));
    check("csr_illegal", 64'(csr_illegal), 64'(m_ill));
  endtask

  task automatic idle_inputs();
    reset = 1'b0; csr_valid = 1'b0; csr_addr = '0; csr_op = '0; csr_wdata = '0;
    flag_valid = '0; flag_data = '0; rm_in = '0;
  endtask

  task automatic access(input logic [11:0] a, input logic [1:0] op, input logic [XLEN-1:0] wd);
    csr_valid = 1'b1; csr_addr = a; csr_op = op; csr_wdata = wd;
  endtask

  int n_acc;
  logic [4:0] s_fflags;
  logic [2:0] s_frm;
  logic       s_dirty;
  int sel;

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(posedge clock);
    #1;
    m_fflags = '0; m_frm = '0; m_dirty = 1'b0; m_resp = 1'b0; m_rdata = '0; m_ill = 1'b0;
    step();
    reset = 1'b0;
    check("rst_ready", 64'(csr_ready), 64'd1);
    check("rst_rvalid", 64'(csr_rvalid), 64'd0);
    check("rst_fflags", 64'(fflags), 64'd0);
    check("rst_frm", 64'(frm), 64'd0);

    // Write fcsr then read it back.
    access(12'h003, 2'd1, 32'h0000_00E5);
    step();
    check("fcsr_wr_rdata", 64'(csr_rdata), 64'h00);
    idle_inputs(); step();
    access(12'h003, 2'd0, 32'h0);
    step();
    check("fcsr_rd_rdata", 64'(csr_rdata), 64'hE5);
    check("fcsr_frm", 64'(frm), 64'd7);
    check("fcsr_fflags", 64'(fflags), 64'b00101);
    idle_inputs(); step();

    // Clear racing a lane flag report.
    access(12'h001, 2'd1, 32'hFFFF_FF11);
    step();
    idle_inputs(); step();
    access(12'h001, 2'd3, 32'h0000_0001);
    flag_valid = 2'b01; flag_data = 10'b11111_00010;
    step();
    check("clr_rdata", 64'(csr_rdata), 64'h11);
    check("clr_fflags", 64'(fflags), 64'b10010);
    idle_inputs(); step();

    // Dynamic rounding-mode resolution.
    access(12'h002, 2'd1, 32'h0000_0002);
    step();
    idle_inputs(); step();
    rm_in = {3'b101, 3'b111};
    step();
    check("rm0_dyn", 64'(rm_out[2:0]), 64'd2);
    check("rm1_out", 64'(rm_out[5:3]), 64'd0);
    check("rm_ill_vec", 64'(rm_illegal), 64'b10);
    idle_inputs();

    // Unmapped address.
    s_fflags = m_fflags; s_frm = m_frm; s_dirty = m_dirty;
    access(12'h300, 2'd1, 32'hFFFF_FFFF);
    step();
    check("ill_rvalid", 64'(csr_rvalid), 64'd1);
    check("ill_flag", 64'(csr_illegal), 64'd1);
    check("ill_rdata", 64'(csr_rdata), 64'd0);
    check("ill_fflags", 64'(fflags), 64'(s_fflags));
    check("ill_frm", 64'(frm), 64'(s_frm));
    check("ill_dirty", 64'(fs_dirty), 64'(s_dirty));
    idle_inputs(); step();

    // Back-to-back requests: one accept every other cycle.
    n_acc = 0;
    access(12'h001, 2'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("ready_pat", 64'(csr_ready), 64'((i % 2) == 0));
      step();
      if (csr_rvalid) n_acc++;
    end
    check("accept_cnt", 64'(n_acc), 64'd2);
    idle_inputs(); step();

    // Reset while a response is pending.
    access(12'h003, 2'd1, 32'h0000_00FF);
    step();
    idle_inputs();
    reset = 1'b1; flag_valid = 2'b11; flag_data = 10'b11111_11111;
    step();
    check("rstr_rvalid", 64'(csr_rvalid), 64'd0);
    check("rstr_fflags", 64'(fflags), 64'd0);
    check("rstr_frm", 64'(frm), 64'd0);
    check("rstr_dirty", 64'(fs_dirty), 64'd0);
    idle_inputs(); step();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 59) == 0);
      csr_valid = $urandom_range(0, 1) == 1;
      sel = $urandom_range(0, 4);
      case (sel)
        0: csr_addr = 12'h001;
        1: csr_addr = 12'h002;
        2, 4: csr_addr = 12'h003;
        default: csr_addr = 12'($urandom);
      endcase
      csr_op    = 2'($urandom);
      csr_wdata = $urandom;
      if ($urandom_range(0, 3) == 0) csr_wdata = csr_wdata & 32'hFFFF_FF00;
      flag_valid = NL'($urandom);
      flag_data  = 10'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 2) != 0) flag_valid = '0;
      rm_in = 6'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
